// File: rtl/systolic_pkg.sv
// Shared types and default widths for the systolic matrix engine.
// Provides the controller state enum and DW/AW/IDXW defaults.
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FEED,
    DRAIN,
    WRITE
  } state_t;

  localparam int DW_DEF   = 8;
  localparam int AW_DEF   = 32;
  localparam int IDXW_DEF = 16;

endpackage

// File: rtl/systolic_pe.sv
// Output-stationary MAC cell: adds (a+a_offset)*(b+b_offset) into acc.
// Ports: clear/enable, offsets, a/b data+valid in and out, acc out.
module systolic_pe
  import systolic_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          enable,
  input  logic [DW:0]   a_offset,
  input  logic [DW:0]   b_offset,
  input  logic [DW-1:0] a_in,
  input  logic          a_vin,
  input  logic [DW-1:0] b_in,
  input  logic          b_vin,
  output logic [DW-1:0] a_out,
  output logic          a_vout,
  output logic [DW-1:0] b_out,
  output logic          b_vout,
  output logic [AW-1:0] acc
);

  // Offset operands need DW+2 bits; the product fits exactly in PW.
  localparam int PW = 2 * DW + 4;
  localparam int XW = (AW > PW) ? AW : PW;

  logic signed [DW+1:0] a_s;
  logic signed [DW+1:0] b_s;
  logic signed [PW-1:0] prod;
  logic signed [XW-1:0] prod_x;

  assign a_s    = (DW+2)'($signed(a_in)) + (DW+2)'($signed(a_offset));
  assign b_s    = (DW+2)'($signed(b_in)) + (DW+2)'($signed(b_offset));
  assign prod   = PW'(a_s) * PW'(b_s);
  assign prod_x = XW'(prod);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      a_out  <= '0;
      a_vout <= 1'b0;
      b_out  <= '0;
      b_vout <= 1'b0;
    end else begin
      if (clear) begin
        acc <= '0;
      end else if (enable && a_vin && b_vin) begin
        acc <= acc + prod_x[AW-1:0];
      end
      if (enable) begin
        a_out  <= a_in;
        a_vout <= a_vin;
        b_out  <= b_in;
        b_vout <= b_vin;
      end
    end
  end

endmodule

// File: rtl/systolic_array_gen.sv
// N x N output-stationary int8 matmul engine with skewed edge feed.
// Ports: start/K/offsets/acc_mode in, A/B read ports, C write port, busy/done.
module systolic_array_gen
  import systolic_pkg::*;
#(
  parameter int N    = 4,
  parameter int DW   = DW_DEF,
  parameter int AW   = AW_DEF,
  parameter int IDXW = IDXW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            acc_mode,
  input  logic [IDXW-1:0] K,
  input  logic [DW:0]     A_offset,
  input  logic [DW:0]     B_offset,
  output logic [IDXW-1:0] A_index,
  input  logic [N*DW-1:0] A_data,
  output logic [IDXW-1:0] B_index,
  input  logic [N*DW-1:0] B_data,
  output logic [IDXW-1:0] C_index,
  output logic [N*AW-1:0] C_data_out,
  output logic            C_wr_en,
  output logic            busy,
  output logic            done
);

  localparam int RW = $clog2(N);

  state_t          state, state_n;
  logic [IDXW-1:0] cnt, cnt_n;
  logic [IDXW-1:0] k_r;
  logic [DW:0]     ao_r, bo_r;
  logic            done_n;
  logic            accept;
  logic            clear;
  logic            shift;
  logic            fvalid;
  logic [RW-1:0]   rsel;

  assign accept = start && (state == IDLE);
  assign clear  = accept && !acc_mode;
  assign shift  = (state == FEED) || (state == DRAIN);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          cnt_n   = '0;
          state_n = (K == '0) ? WRITE : FEED;
        end
      end
      FEED: begin
        if (cnt == k_r - IDXW'(1)) begin
          cnt_n   = '0;
          state_n = DRAIN;
        end else begin
          cnt_n = cnt + IDXW'(1);
        end
      end
      DRAIN: begin
        if (cnt == IDXW'(2 * N - 2)) begin
          cnt_n   = '0;
          state_n = WRITE;
        end else begin
          cnt_n = cnt + IDXW'(1);
        end
      end
      WRITE: begin
        if (cnt == IDXW'(N - 1)) begin
          cnt_n   = '0;
          state_n = IDLE;
          done_n  = 1'b1;
        end else begin
          cnt_n = cnt + IDXW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      done   <= 1'b0;
      k_r    <= '0;
      ao_r   <= '0;
      bo_r   <= '0;
      fvalid <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      done   <= done_n;
      // Reads issued in FEED come back one cycle later.
      fvalid <= (state == FEED);
      if (accept) begin
        k_r  <= K;
        ao_r <= A_offset;
        bo_r <= B_offset;
      end
    end
  end

  assign A_index = (state == FEED) ? cnt : '0;
  assign B_index = (state == FEED) ? cnt : '0;
  assign busy    = (state != IDLE);
  assign C_wr_en = (state == WRITE);
  assign C_index = C_wr_en ? cnt : '0;
  assign rsel    = cnt[RW-1:0];

  logic [DW-1:0] h_d [N][N+1];
  logic          h_v [N][N+1];
  logic [DW-1:0] v_d [N+1][N];
  logic          v_v [N+1][N];
  logic [AW-1:0] acc [N][N];

  // Row lane r and column lane r share the same delay, so one valid
  // chain serves both.
  for (genvar r = 0; r < N; r++) begin : g_skew
    logic [DW-1:0] a_in, b_in;
    assign a_in = fvalid ? A_data[r*DW +: DW] : '0;
    assign b_in = fvalid ? B_data[r*DW +: DW] : '0;
    if (r == 0) begin : g_d0
      assign h_d[0][0] = a_in;
      assign h_v[0][0] = fvalid;
      assign v_d[0][0] = b_in;
      assign v_v[0][0] = fvalid;
    end else begin : g_dn
      logic [DW-1:0] a_sr [r];
      logic [DW-1:0] b_sr [r];
      logic          v_sr [r];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int m = 0; m < r; m++) begin
            a_sr[m] <= '0;
            b_sr[m] <= '0;
            v_sr[m] <= 1'b0;
          end
        end else if (shift) begin
          a_sr[0] <= a_in;
          b_sr[0] <= b_in;
          v_sr[0] <= fvalid;
          for (int m = 1; m < r; m++) begin
            a_sr[m] <= a_sr[m-1];
            b_sr[m] <= b_sr[m-1];
            v_sr[m] <= v_sr[m-1];
          end
        end
      end
      assign h_d[r][0] = a_sr[r-1];
      assign h_v[r][0] = v_sr[r-1];
      assign v_d[0][r] = b_sr[r-1];
      assign v_v[0][r] = v_sr[r-1];
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      systolic_pe #(.DW(DW), .AW(AW)) u_pe (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .enable   (shift),
        .a_offset (ao_r),
        .b_offset (bo_r),
        .a_in     (h_d[i][j]),
        .a_vin    (h_v[i][j]),
        .b_in     (v_d[i][j]),
        .b_vin    (v_v[i][j]),
        .a_out    (h_d[i][j+1]),
        .a_vout   (h_v[i][j+1]),
        .b_out    (v_d[i+1][j]),
        .b_vout   (v_v[i+1][j]),
        .acc      (acc[i][j])
      );
    end
    logic unused_edge;
    assign unused_edge = ^{h_d[i][N], h_v[i][N], v_d[N][i], v_v[N][i]};
    assign C_data_out[i*AW +: AW] = C_wr_en ? acc[rsel][i] : '0;
  end

endmodule

// File: tb/tb_systolic_array_gen.sv
// Bench for systolic_array_gen: table of tiles plus reset/glitch sequences.
// Scoreboard queues hold expected C rows and done cycles.
module tb_systolic_array_gen;
  localparam int N = 4, DW = 8, AW = 32, IDXW = 16;

  logic clk = 1'b0;
  logic rst, start, acc_mode;
  logic [IDXW-1:0] K;
  logic [DW:0] A_offset, B_offset;
  logic [IDXW-1:0] A_index, B_index, C_index;
  logic [N*DW-1:0] A_data, B_data;
  logic [N*AW-1:0] C_data_out;
  logic C_wr_en, busy, done;

  systolic_array_gen #(.N(N), .DW(DW), .AW(AW), .IDXW(IDXW)) dut (
    .clk(clk), .rst(rst), .start(start), .acc_mode(acc_mode), .K(K),
    .A_offset(A_offset), .B_offset(B_offset),
    .A_index(A_index), .A_data(A_data),
    .B_index(B_index), .B_data(B_data),
    .C_index(C_index), .C_data_out(C_data_out), .C_wr_en(C_wr_en),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [N*DW-1:0] a_mem [32];
  logic [N*DW-1:0] b_mem [32];
  always @(posedge clk) begin
    A_data <= a_mem[A_index[4:0]];
    B_data <= b_mem[B_index[4:0]];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int idx;
    logic [N*AW-1:0] data;
  } row_t;

  typedef struct {
    int k; int ao; int bo; bit accm;
    int pat; int glitch; int chk; int cval;
  } vec_t;

  row_t rq[$];
  int dq[$];
  row_t e;
  longint model [N][N];
  logic [AW-1:0] cap [N][N];
  logic [AW-1:0] saved [N][N];
  int checks = 0, errors = 0;

  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (C_wr_en) begin
        if (rq.size() == 0) begin
          errors++;
          $display("FAIL wr_unexpected cyc=%0d idx=%0d", cyc, C_index);
        end else begin
          e = rq.pop_front();
          if (cyc != e.cyc || C_index != e.idx[IDXW-1:0] || C_data_out != e.data) begin
            errors++;
            $display("FAIL c_row got cyc=%0d idx=%0d data=%h want cyc=%0d idx=%0d data=%h",
                     cyc, C_index, C_data_out, e.cyc, e.idx, e.data);
          end
        end
        for (int j = 0; j < N; j++) cap[C_index[1:0]][j] = C_data_out[j*AW +: AW];
      end else if (C_data_out != '0 || C_index != '0) begin
        errors++;
        $display("FAIL c_idle got idx=%0d data=%h want 0", C_index, C_data_out);
      end
      if (done) begin
        checks++;
        if (dq.size() == 0) begin
          errors++;
          $display("FAIL done_unexpected cyc=%0d want none", cyc);
        end else begin
          if (dq[0] != cyc) begin
            errors++;
            $display("FAIL done_time got %0d want %0d", cyc, dq[0]);
          end
          void'(dq.pop_front());
        end
      end
    end
  end

  task automatic load(input int pat, input int k);
    for (int kk = 0; kk < k; kk++) begin
      for (int l = 0; l < N; l++) begin
        case (pat)
          0: begin
            a_mem[kk][l*DW +: DW] = (kk == l) ? 8'd1 : 8'd0;
            b_mem[kk][l*DW +: DW] = 8'((l + 1) * (kk + 1));
          end
          1: begin
            a_mem[kk][l*DW +: DW] = 8'd1;
            b_mem[kk][l*DW +: DW] = 8'd2;
          end
          2: begin
            a_mem[kk][l*DW +: DW] = 8'($urandom);
            b_mem[kk][l*DW +: DW] = 8'($urandom);
          end
          4: begin
            a_mem[kk][l*DW +: DW] = 8'h80;
            b_mem[kk][l*DW +: DW] = 8'h80;
          end
          default: ;
        endcase
      end
    end
  endtask

  task automatic run_tile(input int k, input int ao, input int bo, input bit accm,
                          input int glitch, input int abort_at);
    int s;
    bit fin;
    logic [N*AW-1:0] d;
    longint sa, sb;
    start = 1'b1;
    K = k[IDXW-1:0];
    A_offset = ao[DW:0];
    B_offset = bo[DW:0];
    acc_mode = accm;
    s = cyc;
    if (!accm) begin
      for (int r = 0; r < N; r++)
        for (int j = 0; j < N; j++) model[r][j] = 0;
    end
    for (int kk = 0; kk < k; kk++)
      for (int r = 0; r < N; r++)
        for (int j = 0; j < N; j++) begin
          sa = longint'($signed(a_mem[kk][r*DW +: DW])) + ao;
          sb = longint'($signed(b_mem[kk][j*DW +: DW])) + bo;
          model[r][j] = model[r][j] + sa * sb;
        end
    for (int r = 0; r < N; r++) begin
      for (int j = 0; j < N; j++) d[j*AW +: AW] = model[r][j][AW-1:0];
      rq.push_back('{(k == 0) ? s + 1 + r : s + k + 2 * N + r, r, d});
    end
    dq.push_back((k == 0) ? s + N + 1 : s + k + 3 * N);
    fin = 1'b0;
    for (int c = 1; c <= 400 && !fin; c++) begin
      @(negedge clk);
      start = (glitch != 0 && c == 3);
      if (start) begin
        K = 16'd7;
        acc_mode = 1'b0;
        A_offset = 9'h1F0;
        B_offset = 9'h011;
      end
      if (abort_at != 0 && c == abort_at) begin
        rst = 1'b1;
        #1;
        checks++;
        if (busy || C_wr_en || done) begin
          errors++;
          $display("FAIL abort_outputs got busy=%b wr=%b done=%b want 0 0 0",
                   busy, C_wr_en, done);
        end
        rq.delete();
        dq.delete();
        for (int r = 0; r < N; r++)
          for (int j = 0; j < N; j++) model[r][j] = 0;
        @(negedge clk);
        rst = 1'b0;
        fin = 1'b1;
      end else if (done) begin
        fin = 1'b1;
      end else if (c == 400) begin
        errors++;
        $display("FAIL done_timeout got none want done within 400 cycles");
      end
    end
  endtask

  vec_t tv [8];

  initial begin
    tv[0] = '{4,  0,  0, 1'b0, 0, 0, 2, 0};
    tv[1] = '{1, -1,  3, 1'b0, 1, 0, 1, 0};
    tv[2] = '{1,  2,  3, 1'b0, 1, 0, 1, 15};
    tv[3] = '{5, -3,  7, 1'b0, 2, 0, 4, 0};
    tv[4] = '{5, -3,  7, 1'b1, 3, 0, 3, 0};
    tv[5] = '{0,  0,  0, 1'b0, 3, 0, 1, 0};
    tv[6] = '{3,  5, -2, 1'b0, 2, 1, 0, 0};
    tv[7] = '{16, -256, -256, 1'b0, 4, 0, 1, 2359296};

    rst = 1'b1; start = 1'b0; acc_mode = 1'b0; K = '0;
    A_offset = '0; B_offset = '0;
    for (int m = 0; m < 32; m++) begin a_mem[m] = '0; b_mem[m] = '0; end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (busy || done || C_wr_en || C_data_out != '0 || A_index != '0 || B_index != '0) begin
      errors++;
      $display("FAIL reset_state got busy=%b done=%b wr=%b c=%h ai=%0d bi=%0d want all 0",
               busy, done, C_wr_en, C_data_out, A_index, B_index);
    end
    @(negedge clk);

    for (int t = 0; t < 8; t++) begin
      load(tv[t].pat, tv[t].k);
      run_tile(tv[t].k, tv[t].ao, tv[t].bo, tv[t].accm, tv[t].glitch, 0);
      for (int r = 0; r < N; r++)
        for (int j = 0; j < N; j++) begin
          case (tv[t].chk)
            1: begin
              checks++;
              if (cap[r][j] != AW'(tv[t].cval)) begin
                errors++;
                $display("FAIL tile%0d_const c[%0d][%0d] got %0d want %0d",
                         t, r, j, $signed(cap[r][j]), tv[t].cval);
              end
            end
            2: begin
              checks++;
              if (cap[r][j] != AW'((j + 1) * (r + 1))) begin
                errors++;
                $display("FAIL identity c[%0d][%0d] got %0d want %0d",
                         r, j, cap[r][j], (j + 1) * (r + 1));
              end
            end
            3: begin
              checks++;
              if (cap[r][j] != AW'(saved[r][j] * 2)) begin
                errors++;
                $display("FAIL acc_double c[%0d][%0d] got %h want %h",
                         r, j, cap[r][j], AW'(saved[r][j] * 2));
              end
            end
            4: saved[r][j] = cap[r][j];
            default: ;
          endcase
        end
    end

    load(2, 3);
    run_tile(3, 4, -5, 1'b0, 0, 6);
    load(2, 2);
    run_tile(2, -7, 9, 1'b1, 0, 0);
    repeat (3) @(negedge clk);

    checks++;
    if (rq.size() != 0 || dq.size() != 0) begin
      errors++;
      $display("FAIL leftover got rows=%0d dones=%0d want 0 0", rq.size(), dq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/systolic_array_gen.md
# systolic_array_gen

Parametrised N×N output-stationary int8 systolic matrix-multiply engine, successor to the fixed 4×4 array in the accelerator datapath. Streams K column/row vectors from synchronous A/B operand buffers, applies signed zero-point offsets to both operands, and writes N result rows to the C buffer. Per-element valid tracking keeps drain and skew cycles from contributing offset products. An accumulate mode lets a tile add onto the previous results.

## Interface
- `N`, default 4: array dimension, 2..16.
- `DW`, default 8: signed operand width.
- `AW`, default 32: signed accumulator width.
- `IDXW`, default 16: index / K width.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: start request; honoured only in IDLE.
- `acc_mode` in 1: sampled with `start`; 1 = keep previous accumulators, 0 = clear them.
- `K` in IDXW: reduction depth; sampled with `start`.
- `A_offset` in DW+1: signed; sampled with `start`.
- `B_offset` in DW+1: signed; sampled with `start`.
- `A_index` out IDXW: A buffer read address.
- `A_data` in N·DW: lane r at `[r*DW +: DW]`; valid one cycle after its index.
- `B_index` out IDXW: B buffer read address.
- `B_data` in N·DW: lane j at `[j*DW +: DW]`; same latency as A.
- `C_index` out IDXW: result row being written.
- `C_data_out` out N·AW: lane j at `[j*AW +: AW]` = C[row][j].
- `C_wr_en` out 1: C write strobe.
- `busy` out 1: high whenever state ≠ IDLE.
- `done` out 1: one-cycle pulse at completion.

## Operation
- Result: C[r][j] = Σ_{k<K} (A_k[r]+A_offset)·(B_k[j]+B_offset).
  - Sums are signed, computed at full precision.
  - Each accumulation wraps modulo 2^AW.
- FSM states: IDLE, FEED, DRAIN, WRITE.
  - IDLE→FEED on `start` when K>0.
  - IDLE→WRITE on `start` when K=0.
  - FEED→DRAIN after K cycles.
  - DRAIN→WRITE after 2N−1 cycles.
  - WRITE→IDLE after N cycles; `done` pulses on the cycle IDLE is re-entered.
- FEED: `A_index` = `B_index` = 0..K−1, one per cycle. Outside FEED both are 0.
- Edge injection:
  - Row lane r is delayed r cycles; column lane j is delayed j cycles (skew shift registers).
  - Each element carries a valid bit, set only for returned FEED reads.
  - Invalid elements enter as data 0 with valid 0.
- PE behaviour:
  - Forwards data and valid right/down each cycle in FEED and DRAIN.
  - Accumulates only when both incoming valids are 1.
  - Holds in WRITE and IDLE.
- Clearing: accumulators clear on the accepted `start` when `acc_mode`=0; otherwise they keep their values.
- WRITE:
  - `C_wr_en`=1 for N cycles.
  - `C_index` = 0..N−1.
  - `C_data_out` = row `C_index`.
  - `C_data_out` is 0 outside WRITE.
- `start` while busy is ignored, and its K/offset/mode are not sampled.
- K=0: writes the current accumulators, i.e. zeros if `acc_mode`=0.

## Timing
- Let cycle s be the cycle where `start` is sampled in IDLE.
- FEED occupies s+1..s+K; read data for step k is returned at s+2+k.
- PE(i,j) accumulates step k at the end of cycle s+2+k+i+j. The last MAC is at s+K+2N−1.
- WRITE occupies s+K+2N..s+K+3N−1.
- `done` pulses at s+K+3N; total latency is K+3N.
- `busy` is high s+1..s+K+3N−1.
- K=0 case: WRITE occupies s+1..s+N; `done` pulses at s+N+1.
- A new `start` is accepted on the `done` cycle (back-to-back tiles).
- Reset (including mid-operation):
  - State goes to IDLE.
  - All accumulators, skew registers and valids go to 0.
  - All outputs go to 0.
  - `done` does not pulse.

## Structure
- Package `systolic_pkg`: FSM state enum and default widths (DW, AW, IDXW).
- Sub-module `systolic_pe`:
  - Ports: clear, enable, offsets, data+valid in/out (left→right and top→bottom), accumulator out.
  - Instantiated N² times with generate loops.
- The skew registers and FSM/counters live in the top module.

## Test plan
- N=4, K=4, offsets 0, A = identity, B rows [1,2,3,4]·k → C row r equals B row r; `done` at s+16.
- N=4, K=1, A all 1, B all 2, A_offset=−1, B_offset=3 → every C element = 0. A second run with A_offset=2 → every C element = 15.
- Same tile run twice, second with `acc_mode`=1 → every C element is exactly double the first run's. DRAIN cycles add nothing, confirming valid gating with nonzero offsets.
- K=0 with `acc_mode`=0 → four zero rows written at s+1..s+4; `done` at s+5.
- `start` pulsed at s+3 mid-tile → ignored; results and `done` timing are unchanged. `start` on the `done` cycle → next tile begins.
- `rst` asserted during DRAIN → `busy`, `C_wr_en`, `done` = 0 immediately. A following K=2 tile with `acc_mode`=1 produces results with no residue from the aborted tile.
